ram_port_arbiter: RTL
=====================

Name: ram_port_arbiter

Overview:
- Shares the single-port, 32-bit-wide data RAM between two requesters: the CPU load/store unit and the VGA scanout fetcher.
- Sits between cpu_i and ram_i.
- Video has fixed priority so scanout never underruns. A starvation counter guarantees the CPU a slot within CPU_MAX_WAIT cycles.
- Read data returns one cycle after grant, routed to the requester that owned that slot.

Parameters:
- ADDR_W, 10, word-address width of the RAM.
- CPU_MAX_WAIT, 4, maximum consecutive cycles the CPU may be denied while requesting (range 1..15).
- WAIT_W, 4, width of the starvation counter; must hold CPU_MAX_WAIT.

Ports:
- i_clk  in  1  system clock, all logic on rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- cpu_req  in  1  CPU access request; held with address/data until cpu_gnt.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_wdata  in  32  CPU write data.
- cpu_wstrb  in  4  byte enables for writes.
- cpu_gnt  out  1  CPU request accepted this cycle.
- cpu_rvalid  out  1  CPU read data valid.
- cpu_rdata  out  32  CPU read data.
- vid_req  in  1  scanout read request; held until vid_gnt.
- vid_addr  in  ADDR_W  scanout word address.
- vid_gnt  out  1  scanout request accepted this cycle.
- vid_rvalid  out  1  scanout read data valid.
- vid_rdata  out  32  scanout read data.
- ram_en  out  1  RAM access enable.
- ram_we  out  4  RAM byte write enables.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data, valid one cycle after ram_en with ram_we == 0.

Behaviour:

Reset:
- Asynchronous, active-high.
- Clears the starvation counter, the owner register and the rvalid registers.
- cpu_rvalid = vid_rvalid = 0. cpu_rdata = vid_rdata = 0.
- Grants and ram_en are 0 while i_rst is high.

Arbitration (combinational, same cycle as request):
- Only cpu_req: grant CPU.
- Only vid_req: grant video.
- Both requesting: grant video, unless wait_cnt == CPU_MAX_WAIT, then grant CPU.
- At most one of cpu_gnt/vid_gnt is high in any cycle.
- With no request: ram_en = 0, ram_we = 0, ram_addr and ram_wdata hold their previous values (registered mux select, no X).

RAM drive:
- ram_en = cpu_gnt | vid_gnt.
- CPU granted: ram_addr = cpu_addr, ram_wdata = cpu_wdata, ram_we = cpu_we ? cpu_wstrb : 4'b0.
- Video granted: ram_addr = vid_addr, ram_we = 0.

Starvation counter wait_cnt:
- Increments (saturating at CPU_MAX_WAIT) on each cycle with cpu_req = 1 and cpu_gnt = 0.
- Clears on any cycle with cpu_gnt = 1 or cpu_req = 0.

Read return, 1-cycle latency:
- An owner register captures {read_granted, is_cpu} at the grant edge.
- Next cycle, the owning requester's rvalid = 1 and its rdata = ram_rdata. The other requester's rvalid = 0 and its rdata holds its last value.
- CPU writes produce no rvalid.
- Back-to-back grants give back-to-back rvalids, with no bubble and no reordering.

Boundary conditions:
- CPU write with cpu_wstrb = 0: granted, ram_en = 1, ram_we = 0, no rvalid.
- Requester drops req before grant: protocol violation; the block simply stops considering it.
- Reset mid-read: the pending rvalid is discarded and never asserted.
- Address wrap is not handled here; addresses pass through unchanged.

Test Plan:
- Reset: assert i_rst mid-cycle with a CPU read pending. All grants, rvalids and ram_en drop immediately. After release, no stale rvalid appears.
- CPU-only read: cpu_req = 1, cpu_we = 0, cpu_addr = 0x004, RAM word 0x004 = 0xDEADBEEF. Expect cpu_gnt in the same cycle and ram_addr = 0x004. Next cycle cpu_rvalid = 1, cpu_rdata = 0xDEADBEEF, vid_rvalid = 0.
- CPU byte write: cpu_addr = 0x000, wdata = 0x000000AA, wstrb = 4'b0001. Expect ram_we = 4'b0001 and no rvalid. A read-back of 0x000 returns 0xAA in the low byte.
- Contention with starvation, CPU_MAX_WAIT = 4: hold both requests continuously. Expect the grant pattern V,V,V,V,C,V,V,V,V,C. wait_cnt reaches 4 before each CPU grant and reads 0 after it.
- Interleaved reads: video addr 0x010 (data 0x11111111), then CPU addr 0x020 (data 0x22222222) on consecutive grants. Expect vid_rvalid then cpu_rvalid on consecutive cycles with matching data, and never both high.
- Idle: no requests for 8 cycles. Expect ram_en = 0, ram_we = 0, no rvalid, wait_cnt = 0.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - CPU / VGA scanout arbiter for the shared single-port data RAM
// Video wins by default; the CPU is forced through after CPU_MAX_WAIT denied cycles.
module ram_port_arbiter #(
  parameter int ADDR_W       = 10,
  parameter int CPU_MAX_WAIT = 4,
  parameter int WAIT_W       = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic [3:0]        cpu_wstrb,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [31:0]       cpu_rdata,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_gnt,
  output logic              vid_rvalid,
  output logic [31:0]       vid_rdata,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam logic [WAIT_W-1:0] MAX_WAIT = WAIT_W'(CPU_MAX_WAIT);

  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_own_rd;
  logic              r_own_cpu;
  logic [31:0]       r_cpu_rdata;
  logic [31:0]       r_vid_rdata;
  logic [ADDR_W-1:0] r_addr_hold;
  logic [31:0]       r_wdata_hold;
  logic              w_starved;
  logic              w_cpu_gnt;
  logic              w_vid_gnt;

  assign w_starved = (r_wait_cnt == MAX_WAIT);

  always_comb begin
    w_cpu_gnt = 1'b0;
    w_vid_gnt = 1'b0;
    if (!i_rst) begin
      if (cpu_req && (!vid_req || w_starved)) begin
        w_cpu_gnt = 1'b1;
      end else if (vid_req) begin
        w_vid_gnt = 1'b1;
      end
    end
  end

  // Idle cycles replay the last driven address/data so the RAM pins never float to X.
  always_comb begin
    ram_addr  = r_addr_hold;
    ram_wdata = r_wdata_hold;
    ram_we    = 4'b0000;
    if (w_cpu_gnt) begin
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
      ram_we    = cpu_we ? cpu_wstrb : 4'b0000;
    end else if (w_vid_gnt) begin
      ram_addr = vid_addr;
    end
  end

  assign ram_en  = w_cpu_gnt | w_vid_gnt;
  assign cpu_gnt = w_cpu_gnt;
  assign vid_gnt = w_vid_gnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wait_cnt   <= '0;
      r_own_rd     <= 1'b0;
      r_own_cpu    <= 1'b0;
      r_cpu_rdata  <= '0;
      r_vid_rdata  <= '0;
      r_addr_hold  <= '0;
      r_wdata_hold <= '0;
    end else begin
      if (w_cpu_gnt || !cpu_req) begin
        r_wait_cnt <= '0;
      end else if (r_wait_cnt < MAX_WAIT) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
      r_own_rd  <= w_vid_gnt | (w_cpu_gnt & ~cpu_we);
      r_own_cpu <= w_cpu_gnt;
      if (ram_en) begin
        r_addr_hold  <= ram_addr;
        r_wdata_hold <= ram_wdata;
      end
      if (r_own_rd && r_own_cpu) begin
        r_cpu_rdata <= ram_rdata;
      end
      if (r_own_rd && !r_own_cpu) begin
        r_vid_rdata <= ram_rdata;
      end
    end
  end

  // Read data is forwarded straight from the RAM in the return cycle, then held.
  assign cpu_rvalid = r_own_rd & r_own_cpu;
  assign vid_rvalid = r_own_rd & ~r_own_cpu;
  assign cpu_rdata  = cpu_rvalid ? ram_rdata : r_cpu_rdata;
  assign vid_rdata  = vid_rvalid ? ram_rdata : r_vid_rdata;

endmodule
